// File: rtl/fft_pkg.sv
// Shared definitions for the 64-point radix-2 FFT control slice.
//   N, LOG2N, NB : transform size, stage count, butterflies per stage
//   fft_state_t  : sequencer state encoding
//   bitrev6      : 6-bit bit reversal (load-side scatter)
//   rol6         : 6-bit rotate-left (per-stage butterfly address spread)
package fft_pkg;

  localparam int N     = 64;
  localparam int LOG2N = 6;
  localparam int NB    = N / 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    UNLOAD  = 2'd3
  } fft_state_t;

  function automatic logic [5:0] bitrev6(input logic [5:0] x);
    logic [5:0] r;
    for (int b = 0; b < 6; b++) r[b] = x[5-b];
    return r;
  endfunction

  // Rotating the doubled word left and taking the top half gives a
  // rotate without a variable-width right shift.
  function automatic logic [5:0] rol6(input logic [5:0] x, input logic [2:0] sh);
    logic [11:0] d;
    d = {x, x} << sh;
    return d[11:6];
  endfunction

endpackage

// File: rtl/fft_sequencer_if.sv
// Handshake and RAM/ROM control bundle of the FFT sequencer.
//   master : sequencer side (drives addresses, strobes, status)
//   slave  : environment side (drives start, in_valid, out_ready)
// Signals: start, in_valid, in_ready, ram_write, ram_addr_a, ram_addr_b,
//          twiddle_addr, bfly_valid, out_valid, out_ready, busy, done.
interface fft_sequencer_if;
  import fft_pkg::*;

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             ram_write;
  logic [LOG2N-1:0] ram_addr_a;
  logic [LOG2N-1:0] ram_addr_b;
  logic [LOG2N-2:0] twiddle_addr;
  logic             bfly_valid;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  modport master (
    input  start, in_valid, out_ready,
    output in_ready, ram_write, ram_addr_a, ram_addr_b, twiddle_addr,
           bfly_valid, out_valid, busy, done
  );

  modport slave (
    output start, in_valid, out_ready,
    input  in_ready, ram_write, ram_addr_a, ram_addr_b, twiddle_addr,
           bfly_valid, out_valid, busy, done
  );

endinterface

// File: rtl/fft_addr_gen.sv
// Combinational address decode for the FFT sequencer.
// Inputs : state, s (stage), i (butterfly index), k (pair index)
// Outputs: ram_addr_a, ram_addr_b, twiddle_addr
//   LOAD    : bit-reversed scatter of sample pair 2k / 2k+1
//   COMPUTE : operand pair rol6(2i, s) / rol6(2i+1, s), twiddle = top s bits of i
//   UNLOAD  : natural order 2k / 2k+1
//   IDLE    : all zero
module fft_addr_gen
  import fft_pkg::*;
(
  input  fft_state_t       state,
  input  logic [2:0]       s,
  input  logic [4:0]       i,
  input  logic [4:0]       k,
  output logic [LOG2N-1:0] ram_addr_a,
  output logic [LOG2N-1:0] ram_addr_b,
  output logic [LOG2N-2:0] twiddle_addr
);

  always_comb begin
    ram_addr_a   = '0;
    ram_addr_b   = '0;
    twiddle_addr = '0;
    unique case (state)
      LOAD: begin
        ram_addr_a = bitrev6({k, 1'b0});
        ram_addr_b = bitrev6({k, 1'b1});
      end
      COMPUTE: begin
        ram_addr_a   = rol6({i, 1'b0}, s);
        ram_addr_b   = rol6({i, 1'b1}, s);
        // Mask keeps the s most significant bits of i; empty at s=0.
        twiddle_addr = i & (5'b11111 << (3'd5 - s));
      end
      UNLOAD: begin
        ram_addr_a = {k, 1'b0};
        ram_addr_b = {k, 1'b1};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fft_sequencer.sv
// Control FSM for a 64-point in-place radix-2 FFT over a dual-port RAM
// and twiddle ROM. Phases: IDLE -> LOAD -> COMPUTE -> UNLOAD -> IDLE.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : fft_sequencer_if.master (handshakes, RAM/ROM control, status)
// Parameter:
//   BFLY_LAT   : butterfly datapath latency 0..7; each butterfly holds its
//                addresses for BFLY_LAT+1 cycles (read at phase 0, write at last)
// Optional build macro FFT_STAGE_OUT_EN adds:
//   stage_idx  : current stage in COMPUTE, else 0
//   stage_done : pulses in the cycle of each stage's final write
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int BFLY_LAT = 0
) (
  input  logic             clk,
  input  logic             reset,
  fft_sequencer_if.master  bus
`ifdef FFT_STAGE_OUT_EN
  ,
  output logic [2:0]       stage_idx,
  output logic             stage_done
`endif
);

  localparam logic [2:0] LAT        = 3'(BFLY_LAT);
  localparam logic [4:0] LAST_IDX   = 5'(NB - 1);
  localparam logic [2:0] LAST_STAGE = 3'(LOG2N - 1);

  fft_state_t state_q, state_d;
  logic [4:0] k_q, k_d;
  logic [2:0] s_q, s_d;
  logic [4:0] i_q, i_d;
  logic [2:0] phase_q, phase_d;
  logic       done_q, done_d;
  logic       last_phase;

  assign last_phase = (phase_q == LAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      s_q     <= '0;
      i_q     <= '0;
      phase_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      i_q     <= i_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    i_d     = i_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          k_d     = '0;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          k_d = k_q + 5'd1;
          if (k_q == LAST_IDX) begin
            state_d = COMPUTE;
            s_d     = '0;
            i_d     = '0;
            phase_d = '0;
          end
        end
      end
      COMPUTE: begin
        if (last_phase) begin
          phase_d = '0;
          i_d     = i_q + 5'd1;
          if (i_q == LAST_IDX) begin
            s_d = s_q + 3'd1;
            if (s_q == LAST_STAGE) begin
              state_d = UNLOAD;
              k_d     = '0;
              s_d     = '0;
            end
          end
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      UNLOAD: begin
        // out_valid is constantly high here, so out_ready alone completes a handshake.
        if (bus.out_ready) begin
          k_d = k_q + 5'd1;
          if (k_q == LAST_IDX) begin
            state_d = IDLE;
            k_d     = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready   = (state_q == LOAD);
  assign bus.out_valid  = (state_q == UNLOAD);
  assign bus.busy       = (state_q != IDLE);
  assign bus.bfly_valid = (state_q == COMPUTE) && (phase_q == 3'd0);
  assign bus.ram_write  = ((state_q == LOAD) && bus.in_valid) ||
                          ((state_q == COMPUTE) && last_phase);
  assign bus.done       = done_q;

  fft_addr_gen u_addr_gen (
    .state        (state_q),
    .s            (s_q),
    .i            (i_q),
    .k            (k_q),
    .ram_addr_a   (bus.ram_addr_a),
    .ram_addr_b   (bus.ram_addr_b),
    .twiddle_addr (bus.twiddle_addr)
  );

`ifdef FFT_STAGE_OUT_EN
  assign stage_idx  = (state_q == COMPUTE) ? s_q : 3'd0;
  assign stage_done = (state_q == COMPUTE) && last_phase && (i_q == LAST_IDX);
`endif

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer: one instance with BFLY_LAT=0 and one
// with BFLY_LAT=2 share clock, reset and input stimulus.
module tb_fft_sequencer;

  logic clk;
  logic reset;
  logic start;
  logic in_valid;
  logic out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  fft_sequencer_if i0 ();
  fft_sequencer_if i2 ();

  assign i0.start     = start;
  assign i0.in_valid  = in_valid;
  assign i0.out_ready = out_ready;
  assign i2.start     = start;
  assign i2.in_valid  = in_valid;
  assign i2.out_ready = out_ready;

`ifdef FFT_STAGE_OUT_EN
  logic [2:0] stage_idx0, stage_idx2;
  logic       stage_done0, stage_done2;
`endif

  fft_sequencer #(.BFLY_LAT(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (i0)
`ifdef FFT_STAGE_OUT_EN
    ,
    .stage_idx  (stage_idx0),
    .stage_done (stage_done0)
`endif
  );

  fft_sequencer #(.BFLY_LAT(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (i2)
`ifdef FFT_STAGE_OUT_EN
    ,
    .stage_idx  (stage_idx2),
    .stage_done (stage_done2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int br6(input int x);
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) if (x[b]) r = r | (1 << (5 - b));
    return r;
  endfunction

  function automatic int rolm(input int x, input int s);
    return ((x << s) | (x >> (6 - s))) & 63;
  endfunction

  function automatic int twm(input int i, input int s);
    return i & ((31 << (5 - s)) & 31);
  endfunction

  // Packed view of every control output; zero means fully idle.
  task automatic check_idle(input string tag);
    check({tag, "_d0"}, {i0.busy, i0.in_ready, i0.out_valid, i0.ram_write, i0.bfly_valid,
                         i0.done, i0.ram_addr_a, i0.ram_addr_b, i0.twiddle_addr}, 32'd0);
    check({tag, "_d2"}, {i2.busy, i2.in_ready, i2.out_valid, i2.ram_write, i2.bfly_valid,
                         i2.done, i2.ram_addr_a, i2.ram_addr_b, i2.twiddle_addr}, 32'd0);
`ifdef FFT_STAGE_OUT_EN
    check({tag, "_stage"}, {stage_idx0, stage_done0, stage_idx2, stage_done2}, 32'd0);
`endif
  endtask

  // 32 pair handshakes, one stall cycle at k=1, a stray start pulse at k=5.
  task automatic do_load(input bit chk);
    int  k;
    int  errs;
    bit  stalled;
    k = 0;
    errs = 0;
    stalled = 0;
    while (k < 32) begin
      @(negedge clk);
      if (k == 1 && !stalled) begin
        stalled  = 1;
        in_valid = 1'b0;
        start    = 1'b0;
        #1;
        if (chk) begin
          check("load_stall_wr", i0.ram_write, 0);
          check("load_stall_a", i0.ram_addr_a, 16);
          check("load_stall_rdy", i0.in_ready, 1);
        end
      end else begin
        in_valid = 1'b1;
        start    = (k == 5);
        #1;
        if (i0.ram_addr_a !== 6'(br6(2 * k)) || i0.ram_addr_b !== 6'(br6(2 * k + 1)) ||
            i0.ram_write !== 1'b1 || i0.in_ready !== 1'b1) errs++;
        if (chk) begin
          if (k == 0) begin
            check("load_k0", {i0.ram_addr_a, i0.ram_addr_b, i0.ram_write}, {6'd0, 6'd32, 1'b1});
          end
          if (k == 1) check("load_k1", {i0.ram_addr_a, i0.ram_addr_b}, {6'd16, 6'd48});
          if (k == 6) check("load_k6_after_start", {i0.ram_addr_a, i0.ram_addr_b}, {6'd12, 6'd44});
          if (k == 31) check("load_k31", {i0.ram_addr_a, i0.ram_addr_b}, {6'd31, 6'd63});
        end
        k++;
      end
    end
    if (chk) check("load_model_errs", errs, 0);
  endtask

  int err0, err2, wr0, wr2, s_m, i_m, b_m, p_m, sd_cnt;
  int sd_idx [6];

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset");

    // start together with reset must be ignored
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    #1;
    check("start_in_reset_busy", i0.busy, 0);

    // first transform
    @(negedge clk);
    start = 1'b1;
    #1;
    check("idle_before_start", {i0.busy, i0.in_ready}, 0);
    do_load(1);

    err0 = 0; err2 = 0; wr0 = 0; wr2 = 0; sd_cnt = 0;
    for (int n = 0; n <= 576; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      #1;
      if (n < 192) begin
        s_m = n / 32;
        i_m = n % 32;
        if (i0.ram_addr_a !== 6'(rolm(2 * i_m, s_m)) || i0.ram_addr_b !== 6'(rolm(2 * i_m + 1, s_m)) ||
            i0.twiddle_addr !== 5'(twm(i_m, s_m)) || i0.ram_write !== 1'b1 ||
            i0.bfly_valid !== 1'b1 || i0.busy !== 1'b1) err0++;
      end
      if (i0.ram_write === 1'b1) wr0++;
      if (n < 576) begin
        b_m = n / 3;
        p_m = n % 3;
        s_m = b_m / 32;
        i_m = b_m % 32;
        if (i2.ram_addr_a !== 6'(rolm(2 * i_m, s_m)) || i2.ram_addr_b !== 6'(rolm(2 * i_m + 1, s_m)) ||
            i2.twiddle_addr !== 5'(twm(i_m, s_m)) || i2.ram_write !== (p_m == 2) ||
            i2.bfly_valid !== (p_m == 0)) err2++;
      end
      if (i2.ram_write === 1'b1) wr2++;
`ifdef FFT_STAGE_OUT_EN
      if (stage_done0 === 1'b1) begin
        if (sd_cnt < 6) sd_idx[sd_cnt] = int'(stage_idx0);
        sd_cnt++;
      end
`endif
      if (n == 0) begin
        check("cmp_s0_i0", {i0.ram_addr_a, i0.ram_addr_b, i0.twiddle_addr}, {6'd0, 6'd1, 5'd0});
        check("cmp_first_strobes", {i0.bfly_valid, i0.ram_write, i0.in_ready}, {1'b1, 1'b1, 1'b0});
      end
      if (n == 33) check("cmp_s1_i1", {i0.ram_addr_a, i0.ram_addr_b, i0.twiddle_addr}, {6'd4, 6'd6, 5'd0});
      if (n == 191) check("cmp_s5_i31", {i0.ram_addr_a, i0.ram_addr_b, i0.twiddle_addr}, {6'd31, 6'd63, 5'd31});
      if (n == 192) check("cmp0_to_unload", {i0.out_valid, i0.ram_write}, {1'b1, 1'b0});
      if (n == 3) check("lat2_ph0", {i2.ram_addr_a, i2.ram_addr_b, i2.bfly_valid, i2.ram_write}, {6'd2, 6'd3, 1'b1, 1'b0});
      if (n == 4) check("lat2_ph1", {i2.ram_addr_a, i2.ram_addr_b, i2.bfly_valid, i2.ram_write}, {6'd2, 6'd3, 1'b0, 1'b0});
      if (n == 5) check("lat2_ph2", {i2.ram_addr_a, i2.ram_addr_b, i2.bfly_valid, i2.ram_write}, {6'd2, 6'd3, 1'b0, 1'b1});
      if (n == 575) check("lat2_last", {i2.out_valid, i2.ram_write}, {1'b0, 1'b1});
      if (n == 576) check("lat2_to_unload", {i2.out_valid, i2.ram_write}, {1'b1, 1'b0});
    end
    check("cmp0_model_errs", err0, 0);
    check("cmp2_model_errs", err2, 0);
    check("cmp0_write_count", wr0, 192);
    check("cmp2_write_count", wr2, 192);
`ifdef FFT_STAGE_OUT_EN
    check("stage_done_count", sd_cnt, 6);
    for (int j = 0; j < 6; j++) check("stage_idx_at_done", sd_idx[j], j);
`endif

    // unload with a 5-cycle downstream stall at k=7
    err0 = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 7) begin
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          if (j > 0) @(negedge clk);
          #1;
          if (j == 0 || j == 4)
            check("unload_stall", {i0.ram_addr_a, i0.ram_addr_b, i0.out_valid, i2.ram_addr_a},
                  {6'd14, 6'd15, 1'b1, 6'd14});
        end
        @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      if (i0.ram_addr_a !== 6'(2 * k) || i0.ram_addr_b !== 6'(2 * k + 1) || i0.out_valid !== 1'b1 ||
          i0.ram_write !== 1'b0 || i2.ram_addr_a !== 6'(2 * k) || i2.out_valid !== 1'b1) err0++;
      if (k == 0) check("unload_k0", {i0.ram_addr_a, i0.ram_addr_b, i0.done}, {6'd0, 6'd1, 1'b0});
    end
    check("unload_model_errs", err0, 0);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("done_pulse", {i0.done, i2.done, i0.busy, i0.out_valid}, {1'b1, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    #1;
    check("done_once", {i0.done, i2.done, i0.busy}, 0);

    // second transform, aborted by reset in stage 3
    @(negedge clk);
    start = 1'b1;
    do_load(0);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
    end
    @(negedge clk);
    #1;
    check("abort_s3_i4", {i0.ram_addr_a, i0.ram_addr_b, i0.twiddle_addr, i0.busy},
          {6'd1, 6'd9, 5'd4, 1'b1});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle("reset_mid_compute");
    @(negedge clk);
    #1;
    check_idle("idle_after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
